// File: rtl/pre_arbiter_pkg.sv
// pre_arbiter_pkg: shared defaults, state encodings and descriptor type for pre_arbiter_mp
package pre_arbiter_pkg;
  localparam int DEF_PORTS = 4;
  localparam int DEF_DEPTH_RAM = 2048;
  localparam int DEF_FIFO_WIDTH = 11;
  localparam int DEF_DESC_DEPTH = 8;
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;
  // descriptor fields are sized for the widest supported address/length; users truncate
  localparam int DESC_W = 16;
  typedef enum logic [1:0] {P_WAIT, P_IDLE, P_RECV} port_state_t;
  typedef enum logic [1:0] {A_IDLE, A_REQ, A_GAP} arb_state_t;
  typedef struct packed {
    logic [DESC_W-1:0] start;
    logic [DESC_W-1:0] length;
  } desc_t;
endpackage

// File: rtl/pre_arbiter_mp_port_ctrl.sv
// pa_port_ctrl: per-port frame writer, length/used-byte tracking and descriptor FIFO
module pa_port_ctrl
  import pre_arbiter_pkg::*;
#(
  parameter int pDEPTH_RAM = DEF_DEPTH_RAM,
  parameter int pFIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int pDESC_DEPTH = DEF_DESC_DEPTH,
  parameter int pMIN_LEN = DEF_MIN_LEN,
  parameter int pMAX_LEN = DEF_MAX_LEN,
  localparam int AW = $clog2(pDEPTH_RAM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dv,
  input  logic [7:0]             rx_d,
  input  logic                   error,
  input  logic                   pop,
  output logic                   wr_en,
  output logic [7:0]             wr_data,
  output logic [AW-1:0]          wr_addr,
  output logic                   drop,
  output logic                   empty,
  output logic [AW-1:0]          head_start,
  output logic [pFIFO_WIDTH-1:0] head_len
);
  localparam int DW = $clog2(pDESC_DEPTH);
  localparam int SW = (AW > pFIFO_WIDTH ? AW : pFIFO_WIDTH) + 2;
  localparam logic [pFIFO_WIDTH-1:0] LSAT = pFIFO_WIDTH'(pMAX_LEN + 1);
  port_state_t state, state_nx;
  logic [AW-1:0] ptr, start;
  logic [pFIFO_WIDTH-1:0] len, len_nx;
  logic [AW:0] used;
  logic bad, bad_nx, active, wr_ok, ending, full, commit;
  desc_t mem [pDESC_DEPTH];
  logic [DW-1:0] rd, wr;
  logic [DW:0] cnt;
  always_comb begin
    state_nx = state == P_WAIT ? (dv ? P_WAIT : P_IDLE) : (dv ? P_RECV : P_IDLE);
    active = dv && state != P_WAIT;
    len_nx = state == P_IDLE ? pFIFO_WIDTH'(1) : (len == LSAT ? len : len + 1);
    bad_nx = (state == P_RECV && bad) || error || (SW'(used) + SW'(len_nx) >= SW'(pDEPTH_RAM));
    wr_ok = active && !(state == P_RECV && bad);
    ending = state == P_RECV && !dv;
    full = cnt == (DW+1)'(pDESC_DEPTH);
    commit = ending && !bad && !full && len >= pFIFO_WIDTH'(pMIN_LEN) && len <= pFIFO_WIDTH'(pMAX_LEN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= P_WAIT;
      ptr <= '0;
      start <= '0;
      len <= '0;
      bad <= 1'b0;
      used <= '0;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      wr_en <= wr_ok;
      wr_data <= rx_d;
      wr_addr <= ptr;
      drop <= ending && !commit;
      if (active) begin
        len <= len_nx;
        bad <= bad_nx;
        if (state == P_IDLE) start <= ptr;
      end
      if (wr_ok) ptr <= ptr + 1;
      else if (ending && !commit) ptr <= start;
      used <= used + (commit ? (AW+1)'(len) : '0) - (pop ? (AW+1)'(head_len) : '0);
      if (commit) wr <= wr + 1;
      if (pop) rd <= rd + 1;
      cnt <= cnt + (DW+1)'(commit) - (DW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (commit) mem[wr] <= '{start: DESC_W'(start), length: DESC_W'(len)};
  end
  assign empty = cnt == '0;
  assign head_start = AW'(mem[rd].start);
  assign head_len = pFIFO_WIDTH'(mem[rd].length);
endmodule

// File: rtl/pre_arbiter_mp.sv
// pre_arbiter_mp: multi-port frame pre-buffer with round-robin descriptor arbiter
module pre_arbiter_mp
  import pre_arbiter_pkg::*;
#(
  parameter int pPORTS = DEF_PORTS,
  parameter int pDEPTH_RAM = DEF_DEPTH_RAM,
  parameter int pFIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int pDESC_DEPTH = DEF_DESC_DEPTH,
  parameter int pMIN_LEN = DEF_MIN_LEN,
  parameter int pMAX_LEN = DEF_MAX_LEN,
  localparam int AW = $clog2(pDEPTH_RAM),
  localparam int PW = $clog2(pPORTS)
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic [pPORTS-1:0]      idv,
  input  logic [8*pPORTS-1:0]    irx_d,
  input  logic [pPORTS-1:0]      i_error,
  input  logic                   i_w_permition,
  input  logic                   i_ack,
  output logic [pPORTS-1:0]      o_wr_en,
  output logic [8*pPORTS-1:0]    o_wr_data,
  output logic [AW*pPORTS-1:0]   o_wr_addr,
  output logic                   o_request,
  output logic [PW-1:0]          o_port_num,
  output logic [AW-1:0]          o_start_adress,
  output logic [pFIFO_WIDTH-1:0] o_length,
  output logic [pPORTS-1:0]      o_drop
);
  arb_state_t st, st_nx;
  logic [PW-1:0] grant, last_grant, sel, idx;
  logic found;
  logic [pPORTS-1:0] empty, pop;
  logic [AW-1:0] hs [pPORTS];
  logic [pFIFO_WIDTH-1:0] hl [pPORTS];
  for (genvar p = 0; p < pPORTS; p++) begin : g_port
    pa_port_ctrl #(
      .pDEPTH_RAM(pDEPTH_RAM), .pFIFO_WIDTH(pFIFO_WIDTH), .pDESC_DEPTH(pDESC_DEPTH),
      .pMIN_LEN(pMIN_LEN), .pMAX_LEN(pMAX_LEN)
    ) u_port (
      .clk(iclk), .rst(i_rst), .dv(idv[p]), .rx_d(irx_d[8*p+:8]), .error(i_error[p]),
      .pop(pop[p]), .wr_en(o_wr_en[p]), .wr_data(o_wr_data[8*p+:8]),
      .wr_addr(o_wr_addr[AW*p+:AW]), .drop(o_drop[p]), .empty(empty[p]),
      .head_start(hs[p]), .head_len(hl[p])
    );
  end
  // descending scan so the last hit is the first non-empty port after last_grant
  always_comb begin
    sel = last_grant;
    idx = '0;
    found = 1'b0;
    for (int i = pPORTS; i >= 1; i--) begin
      idx = PW'((int'(last_grant) + i) % pPORTS);
      if (!empty[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    st_nx = st == A_IDLE ? (i_w_permition && found ? A_REQ : A_IDLE)
          : st == A_REQ ? (i_ack ? A_GAP : A_REQ) : A_IDLE;
  end
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      st <= A_IDLE;
      grant <= '0;
      last_grant <= PW'(pPORTS - 1);
    end else begin
      st <= st_nx;
      if (st == A_IDLE && st_nx == A_REQ) begin
        grant <= sel;
        last_grant <= sel;
      end
    end
  end
  assign o_request = st == A_REQ;
  assign pop = (o_request && i_ack) ? pPORTS'(1) << grant : '0;
  assign o_port_num = o_request ? grant : '0;
  assign o_start_adress = o_request ? hs[grant] : '0;
  assign o_length = o_request ? hl[grant] : '0;
endmodule

// File: tb/tb_pre_arbiter_mp.sv
// tb_pre_arbiter_mp: directed self-checking bench for pre_arbiter_mp
module tb_pre_arbiter_mp;
  localparam int P = 4;
  localparam int AW = 11;
  logic iclk = 1'b0;
  logic i_rst = 1'b1;
  logic [P-1:0] idv, i_error;
  logic [8*P-1:0] irx_d;
  logic i_w_permition, i_ack;
  logic [P-1:0] o_wr_en, o_drop;
  logic [8*P-1:0] o_wr_data;
  logic [AW*P-1:0] o_wr_addr;
  logic o_request;
  logic [1:0] o_port_num;
  logic [AW-1:0] o_start_adress;
  logic [10:0] o_length;
  int tests = 0, fails = 0, cyc = 0, end_cyc = 0;
  int rq_port[$], rq_start[$], rq_len[$], rq_cyc[$];
  int drop_cnt[P], wr_cnt[P];
  int drop_cyc = 0, last_addr0 = 0, last_data0 = 0, wrap_cnt = 0;
  pre_arbiter_mp dut (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .i_error(i_error),
    .i_w_permition(i_w_permition), .i_ack(i_ack), .o_wr_en(o_wr_en), .o_wr_data(o_wr_data),
    .o_wr_addr(o_wr_addr), .o_request(o_request), .o_port_num(o_port_num),
    .o_start_adress(o_start_adress), .o_length(o_length), .o_drop(o_drop)
  );
  always #5 iclk = ~iclk;
  initial forever begin
    @(posedge iclk);
    cyc++;
  end
  // acknowledges every request on its first cycle and logs what the DUT shows
  initial begin
    bit req_q, had_wr;
    req_q = 0;
    had_wr = 0;
    i_ack = 1'b0;
    for (int p = 0; p < P; p++) begin
      drop_cnt[p] = 0;
      wr_cnt[p] = 0;
    end
    forever begin
      @(negedge iclk);
      i_ack = o_request;
      if (o_request && !req_q) begin
        rq_port.push_back(int'(o_port_num));
        rq_start.push_back(int'(o_start_adress));
        rq_len.push_back(int'(o_length));
        rq_cyc.push_back(cyc);
      end
      req_q = o_request;
      for (int p = 0; p < P; p++) begin
        if (o_drop[p]) begin
          drop_cnt[p]++;
          drop_cyc = cyc;
        end
        if (o_wr_en[p]) wr_cnt[p]++;
      end
      if (o_wr_en[0]) begin
        if (had_wr && last_addr0 == 2047 && o_wr_addr[AW-1:0] == '0) wrap_cnt++;
        last_addr0 = int'(o_wr_addr[AW-1:0]);
        last_data0 = int'(o_wr_data[7:0]);
        had_wr = 1;
      end else had_wr = 0;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge iclk);
  endtask
  task automatic check(string tag, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic send(logic [P-1:0] m, int n, int err);
    for (int i = 1; i <= n; i++) begin
      idv = m;
      irx_d = {P{8'(i)}};
      i_error = (i == err) ? m : '0;
      tick();
    end
    idv = '0;
    i_error = '0;
    end_cyc = cyc;
    tick();
  endtask
  task automatic wait_reqs(string tag, int n);
    int k = 0;
    while (rq_port.size() < n && k < 100) begin
      tick();
      k++;
    end
    check(tag, rq_port.size(), n);
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
    tick(2);
  endtask
  initial begin
    int b, e, d, wc;
    idv = '0;
    irx_d = '0;
    i_error = '0;
    i_w_permition = 1'b0;
    tick(3);
    check("rst_req", int'(o_request), 0);
    check("rst_wr_en", int'(o_wr_en), 0);
    check("rst_drop", int'(o_drop), 0);
    check("rst_start", int'(o_start_adress), 0);
    i_rst = 1'b0;
    tick(2);
    // single frame, latency and next start
    i_w_permition = 1'b1;
    b = rq_port.size();
    send(4'h1, 100, 0);
    e = end_cyc;
    wait_reqs("t1_req", b + 1);
    check("t1_cyc", rq_cyc[b], e + 2);
    check("t1_port", rq_port[b], 0);
    check("t1_start", rq_start[b], 0);
    check("t1_len", rq_len[b], 100);
    check("t1_wr_cnt", wr_cnt[0], 100);
    check("t1_last_data", last_data0, 100);
    send(4'h1, 100, 0);
    wait_reqs("t1_req2", b + 2);
    check("t1_start2", rq_start[b+1], 100);
    tick(3);
    check("t1_used", int'(dut.g_port[0].u_port.used), 0);
    // four ports commit together
    do_reset();
    b = rq_port.size();
    send(4'hF, 80, 0);
    e = end_cyc;
    wait_reqs("t2_req", b + 4);
    check("t2_cyc", rq_cyc[b], e + 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_port%0d", k), rq_port[b+k], k);
      check($sformatf("t2_start%0d", k), rq_start[b+k], 0);
      check($sformatf("t2_len%0d", k), rq_len[b+k], 80);
    end
    tick(4);
    check("t2_used0", int'(dut.g_port[0].u_port.used), 0);
    check("t2_used1", int'(dut.g_port[1].u_port.used), 0);
    check("t2_used2", int'(dut.g_port[2].u_port.used), 0);
    check("t2_used3", int'(dut.g_port[3].u_port.used), 0);
    // short, oversize and errored frames are dropped
    b = rq_port.size();
    d = drop_cnt[0];
    send(4'h1, 63, 0);
    send(4'h1, 1519, 0);
    send(4'h1, 200, 50);
    tick(2);
    check("t3_drops", drop_cnt[0] - d, 3);
    check("t3_drop_cyc", drop_cyc, end_cyc + 1);
    check("t3_no_req", rq_port.size(), b);
    send(4'h1, 100, 0);
    wait_reqs("t3_req", b + 1);
    check("t3_start", rq_start[b], 80);
    check("t3_len", rq_len[b], 100);
    // descriptor FIFO full on port 1
    i_w_permition = 1'b0;
    b = rq_port.size();
    d = drop_cnt[1];
    for (int k = 0; k < 9; k++) send(4'h2, 64, 0);
    tick(2);
    check("t4_drop9", drop_cnt[1] - d, 1);
    check("t4_no_req", rq_port.size(), b);
    i_w_permition = 1'b1;
    wait_reqs("t4_reqs", b + 8);
    check("t4_port", rq_port[b], 1);
    check("t4_start0", rq_start[b], 80);
    check("t4_start7", rq_start[b+7], 528);
    check("t4_len7", rq_len[b+7], 64);
    send(4'h2, 64, 0);
    wait_reqs("t4_req10", b + 9);
    check("t4_start10", rq_start[b+8], 592);
    check("t4_drop_after", drop_cnt[1] - d, 1);
    // write pointer wrap
    do_reset();
    b = rq_port.size();
    send(4'h1, 1000, 0);
    send(4'h1, 1000, 0);
    wait_reqs("t5_pre", b + 2);
    check("t5_pre_start", rq_start[b+1], 1000);
    wc = wrap_cnt;
    send(4'h1, 100, 0);
    wait_reqs("t5_req", b + 3);
    check("t5_start", rq_start[b+2], 2000);
    check("t5_len", rq_len[b+2], 100);
    check("t5_wrap", wrap_cnt - wc, 1);
    check("t5_last_addr", last_addr0, 51);
    // reset mid-frame, released while idv is high
    do_reset();
    b = rq_port.size();
    d = drop_cnt[0];
    wc = 0;
    for (int i = 1; i <= 60; i++) begin
      idv = 4'h1;
      irx_d = {P{8'(i)}};
      if (i == 40) begin
        i_rst = 1'b1;
        #1;
        check("t6_rst_wr_en", int'(o_wr_en), 0);
        check("t6_rst_req", int'(o_request), 0);
      end
      if (i == 42) wc = wr_cnt[0];
      if (i == 44) i_rst = 1'b0;
      tick();
    end
    idv = '0;
    tick(3);
    check("t6_no_wr", wr_cnt[0], wc);
    check("t6_no_drop", drop_cnt[0], d);
    check("t6_no_req", rq_port.size(), b);
    send(4'h1, 100, 0);
    wait_reqs("t6_req", b + 1);
    check("t6_start", rq_start[b], 0);
    check("t6_len", rq_len[b], 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
